// File: rtl/seq_magnitude_comparator.sv
// seq_magnitude_comparator: multi-cycle MSB-first magnitude compare, DIGIT bits per cycle.
// Signed mode flips both operand MSBs so the unsigned digit walk yields two's-complement order.
module seq_magnitude_comparator #(
  parameter int WIDTH = 8,
  parameter int DIGIT = 1,
  parameter int CW    = $clog2(WIDTH / DIGIT + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             l_out,
  output logic             e_out,
  output logic             g_out,
  output logic [CW-1:0]    digits_used
);

  localparam int NDIG = WIDTH / DIGIT;

  if (WIDTH < 2 || DIGIT < 1 || (WIDTH % DIGIT) != 0) begin : g_bad_param
    $error("seq_magnitude_comparator: WIDTH must be >= 2 and a multiple of DIGIT");
  end

  typedef enum logic {S_IDLE, S_RUN} state_t;

  state_t           r_state, w_state_nxt;
  logic [WIDTH-1:0] r_a, r_b, w_a_nxt, w_b_nxt;
  logic [CW-1:0]    r_idx, w_idx_nxt;
  logic [CW-1:0]    r_used, w_used_nxt;
  logic             r_done, w_done_nxt;
  logic             r_l, r_e, r_g, w_l_nxt, w_e_nxt, w_g_nxt;
  logic [DIGIT-1:0] w_da, w_db;

  assign w_da = r_a[WIDTH-1 -: DIGIT];
  assign w_db = r_b[WIDTH-1 -: DIGIT];

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_a     <= '0;
      r_b     <= '0;
      r_idx   <= '0;
      r_used  <= '0;
      r_done  <= 1'b0;
      r_l     <= 1'b0;
      r_e     <= 1'b0;
      r_g     <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_a     <= w_a_nxt;
      r_b     <= w_b_nxt;
      r_idx   <= w_idx_nxt;
      r_used  <= w_used_nxt;
      r_done  <= w_done_nxt;
      r_l     <= w_l_nxt;
      r_e     <= w_e_nxt;
      r_g     <= w_g_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_a_nxt     = r_a;
    w_b_nxt     = r_b;
    w_idx_nxt   = r_idx;
    w_used_nxt  = r_used;
    w_done_nxt  = 1'b0;
    w_l_nxt     = r_l;
    w_e_nxt     = r_e;
    w_g_nxt     = r_g;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_a_nxt = a;
          w_b_nxt = b;
          if (is_signed) begin
            w_a_nxt[WIDTH-1] = ~a[WIDTH-1];
            w_b_nxt[WIDTH-1] = ~b[WIDTH-1];
          end
          w_idx_nxt   = '0;
          w_state_nxt = S_RUN;
        end
      end
      S_RUN: begin
        if (w_da != w_db) begin
          w_l_nxt     = (w_da < w_db);
          w_g_nxt     = (w_da > w_db);
          w_e_nxt     = 1'b0;
          w_used_nxt  = r_idx + CW'(1);
          w_done_nxt  = 1'b1;
          w_state_nxt = S_IDLE;
        end else if (r_idx == CW'(NDIG - 1)) begin
          w_l_nxt     = 1'b0;
          w_g_nxt     = 1'b0;
          w_e_nxt     = 1'b1;
          w_used_nxt  = CW'(NDIG);
          w_done_nxt  = 1'b1;
          w_state_nxt = S_IDLE;
        end else begin
          w_a_nxt   = r_a << DIGIT;
          w_b_nxt   = r_b << DIGIT;
          w_idx_nxt = r_idx + CW'(1);
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign busy        = (r_state == S_RUN);
  assign done        = r_done;
  assign l_out       = r_l;
  assign e_out       = r_e;
  assign g_out       = r_g;
  assign digits_used = r_used;

endmodule

// File: tb/tb_seq_magnitude_comparator.sv
// Bench for seq_magnitude_comparator: four configurations (8/1, 8/2, 8/4, 32/4) checked
// against an arithmetic reference of signed/unsigned order and first-differing-digit index.
module tb_seq_magnitude_comparator;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        sgn = 1'b0;
  logic [7:0]  a8 = '0, b8 = '0;
  logic [31:0] a32 = '0, b32 = '0;
  logic        st0 = 1'b0, st1 = 1'b0, st2 = 1'b0, st3 = 1'b0;
  logic        bz0, bz1, bz2, bz3, dn0, dn1, dn2, dn3;
  logic        lo0, lo1, lo2, lo3, eo0, eo1, eo2, eo3, go0, go1, go2, go3;
  logic [3:0]  u0;
  logic [2:0]  u1;
  logic [1:0]  u2;
  logic [3:0]  u3;

  int sel = 0;
  logic m_busy, m_done, m_l, m_e, m_g;
  int   m_used;
  int   checks = 0, errors = 0;
  int   prev_f[4];
  int   prev_u[4];

  always #5 clk = ~clk;

  seq_magnitude_comparator #(.WIDTH(8), .DIGIT(1)) u_d81 (
    .clk(clk), .reset(reset), .start(st0), .is_signed(sgn), .a(a8), .b(b8),
    .busy(bz0), .done(dn0), .l_out(lo0), .e_out(eo0), .g_out(go0), .digits_used(u0));
  seq_magnitude_comparator #(.WIDTH(8), .DIGIT(2)) u_d82 (
    .clk(clk), .reset(reset), .start(st1), .is_signed(sgn), .a(a8), .b(b8),
    .busy(bz1), .done(dn1), .l_out(lo1), .e_out(eo1), .g_out(go1), .digits_used(u1));
  seq_magnitude_comparator #(.WIDTH(8), .DIGIT(4)) u_d84 (
    .clk(clk), .reset(reset), .start(st2), .is_signed(sgn), .a(a8), .b(b8),
    .busy(bz2), .done(dn2), .l_out(lo2), .e_out(eo2), .g_out(go2), .digits_used(u2));
  seq_magnitude_comparator #(.WIDTH(32), .DIGIT(4)) u_d324 (
    .clk(clk), .reset(reset), .start(st3), .is_signed(sgn), .a(a32), .b(b32),
    .busy(bz3), .done(dn3), .l_out(lo3), .e_out(eo3), .g_out(go3), .digits_used(u3));

  always_comb begin
    m_busy = 1'b0; m_done = 1'b0; m_l = 1'b0; m_e = 1'b0; m_g = 1'b0; m_used = 0;
    case (sel)
      0: begin m_busy = bz0; m_done = dn0; m_l = lo0; m_e = eo0; m_g = go0; m_used = int'(u0); end
      1: begin m_busy = bz1; m_done = dn1; m_l = lo1; m_e = eo1; m_g = go1; m_used = int'(u1); end
      2: begin m_busy = bz2; m_done = dn2; m_l = lo2; m_e = eo2; m_g = go2; m_used = int'(u2); end
      default: begin m_busy = bz3; m_done = dn3; m_l = lo3; m_e = eo3; m_g = go3; m_used = int'(u3); end
    endcase
  end

  function automatic int wof(input int s);
    return (s == 3) ? 32 : 8;
  endfunction

  function automatic int dof(input int s);
    case (s)
      0:       return 1;
      1:       return 2;
      default: return 4;
    endcase
  endfunction

  // Order from plain integer arithmetic; digit count from the highest differing bit.
  task automatic model(input int w, input int dg, input logic [31:0] av, input logic [31:0] bv,
                       input bit sv, output int flags, output int d);
    longint va, vb;
    logic [31:0] x;
    int p;
    va = longint'(av);
    vb = longint'(bv);
    if (sv && av[w-1]) va = va - (longint'(1) << w);
    if (sv && bv[w-1]) vb = vb - (longint'(1) << w);
    flags = {29'd0, va < vb, va == vb, va > vb};
    x = av ^ bv;
    p = -1;
    for (int i = 0; i < w; i++) if (x[i]) p = i;
    d = (p < 0) ? (w / dg) : ((w - 1 - p) / dg + 1);
  endtask

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic drive_start(input int s, input bit v);
    case (s)
      0: st0 = v;
      1: st1 = v;
      2: st2 = v;
      default: st3 = v;
    endcase
  endtask

  task automatic drive_ops(input int s, input logic [31:0] av, input logic [31:0] bv, input bit sv);
    sgn = sv;
    if (s == 3) begin a32 = av; b32 = bv; end
    else begin a8 = av[7:0]; b8 = bv[7:0]; end
  endtask

  // Issues at the current negedge, returns at the negedge where done is seen.
  task automatic run_cmp(input string tag, input int s, input logic [31:0] av_in,
                         input logic [31:0] bv_in, input bit sv, input bit poke);
    logic [31:0] av, bv;
    int ef, ed, k, hold_ok, got;
    av = (wof(s) == 8) ? (av_in & 32'hFF) : av_in;
    bv = (wof(s) == 8) ? (bv_in & 32'hFF) : bv_in;
    model(wof(s), dof(s), av, bv, sv, ef, ed);
    sel = s;
    drive_ops(s, av, bv, sv);
    drive_start(s, 1'b1);
    @(negedge clk);
    drive_start(s, 1'b0);
    k = 0; hold_ok = 1; got = 0;
    while (k < 40) begin
      if (poke && k == 1) begin
        drive_ops(s, ~av, bv, ~sv);
        drive_start(s, 1'b1);
      end
      @(negedge clk);
      k++;
      if (poke && k == 2) drive_start(s, 1'b0);
      if (m_done) begin got = 1; break; end
      if (m_busy !== 1'b1 || int'({m_l, m_e, m_g}) != prev_f[s] || m_used != prev_u[s])
        hold_ok = 0;
    end
    check({tag, "_done_seen"}, got, 1);
    check({tag, "_latency"}, k, ed);
    check({tag, "_flags"}, int'({m_l, m_e, m_g}), ef);
    check({tag, "_digits_used"}, m_used, ed);
    check({tag, "_busy_low"}, int'(m_busy), 0);
    check({tag, "_hold_during_run"}, hold_ok, 1);
    prev_f[s] = ef;
    prev_u[s] = ed;
    if (poke) begin
      @(negedge clk);
      check({tag, "_no_queued_start_done"}, int'(m_done), 0);
      check({tag, "_no_queued_start_busy"}, int'(m_busy), 0);
    end
  endtask

  task automatic check_zero(input string tag, input int s);
    sel = s;
    #1;
    check({tag, "_busy"}, int'(m_busy), 0);
    check({tag, "_done"}, int'(m_done), 0);
    check({tag, "_flags"}, int'({m_l, m_e, m_g}), 0);
    check({tag, "_used"}, m_used, 0);
  endtask

  initial begin
    int seen_done;
    logic [31:0] ra, rb;
    for (int i = 0; i < 4; i++) begin prev_f[i] = 0; prev_u[i] = 0; end

    reset = 1'b1;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    for (int s = 0; s < 4; s++) check_zero("reset", s);

    // Reset in the middle of a compare discards it.
    sel = 0;
    drive_ops(0, 32'd25, 32'd25, 1'b0);
    drive_start(0, 1'b1);
    @(negedge clk);
    drive_start(0, 1'b0);
    @(negedge clk);
    @(negedge clk);
    check("midrun_busy_before_reset", int'(m_busy), 1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check_zero("midrun_reset", 0);
    seen_done = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (m_done || m_busy) seen_done = 1;
    end
    check("midrun_no_done_after_reset", seen_done, 0);

    run_cmp("u81_eq",      0, 32'd25,  32'd25,  1'b0, 1'b0);
    run_cmp("u81_gt",      0, 32'd128, 32'd127, 1'b0, 1'b0);
    run_cmp("u81_lt",      0, 32'd37,  32'd79,  1'b0, 1'b0);
    run_cmp("s81_lt",      0, 32'h80,  32'd127, 1'b1, 1'b0);
    run_cmp("u81_gt_same", 0, 32'h80,  32'd127, 1'b0, 1'b0);
    run_cmp("s81_m1_m2",   0, 32'hFF,  32'hFE,  1'b1, 1'b0);
    @(negedge clk);
    run_cmp("u82_gt",      1, 32'd39,  32'd16,  1'b0, 1'b0);
    run_cmp("u84_lt",      2, 32'd20,  32'd100, 1'b0, 1'b0);
    run_cmp("u84_eq",      2, 32'hFF,  32'hFF,  1'b0, 1'b0);

    // Start pulsed while busy is ignored; then a start in the done cycle.
    run_cmp("poke",        0, 32'd6,   32'd5,   1'b0, 1'b1);
    run_cmp("b2b_first",   0, 32'd200, 32'd201, 1'b0, 1'b0);
    check("b2b_done_at_issue", int'(m_done), 1);
    run_cmp("b2b_second",  0, 32'd3,   32'd3,   1'b1, 1'b0);

    for (int n = 0; n < 1000; n++) begin
      ra = $urandom;
      case ($urandom_range(0, 3))
        0:       rb = ra;
        1:       rb = $urandom;
        default: rb = ra ^ ($urandom >> $urandom_range(0, 31));
      endcase
      if ($urandom_range(0, 7) == 0) @(negedge clk);
      run_cmp("rand32", 3, ra, rb, 1'($urandom_range(0, 1)), 1'b0);
    end

    for (int n = 0; n < 60; n++) begin
      ra = $urandom;
      rb = ($urandom_range(0, 2) == 0) ? ra : (ra ^ ($urandom >> $urandom_range(24, 31)));
      run_cmp("rand8", n % 3, ra, rb, 1'($urandom_range(0, 1)), 1'b0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
